// File: rtl/uart_pwm_frame_ctrl.sv
// Parses N_CH-byte duty frames (plus terminator) from a UART byte stream and drives N_CH PWM outputs.
// Duties are applied atomically at period wrap; a link watchdog zeroes outputs when frames stop arriving.
module uart_pwm_frame_ctrl #(
  parameter int         N_CH       = 2,
  parameter int         PERIOD_CNT = 27027,
  parameter logic [7:0] TERM       = 8'h0A,
  parameter int         BYTE_TMO   = 270270,
  parameter int         WDOG_CYC   = 27027027
) (
  input  logic              clk,
  input  logic              reset_uart,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic [N_CH-1:0]   pwm_out,
  output logic [8*N_CH-1:0] duty_bus,
  output logic              frame_strobe,
  output logic              frame_err,
  output logic [15:0]       err_count,
  output logic              link_ok
);

  localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int CW = $clog2(PERIOD_CNT + 1);
  localparam int PW = 8 + CW;
  localparam int TW = (BYTE_TMO > 2) ? $clog2(BYTE_TMO) : 1;
  localparam int WW = (WDOG_CYC > 2) ? $clog2(WDOG_CYC) : 1;

  localparam logic [IW-1:0] IDX_LAST = IW'(N_CH - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(PERIOD_CNT - 1);
  localparam logic [TW-1:0] TMR_LAST = TW'(BYTE_TMO - 1);
  localparam logic [WW-1:0] WD_LAST  = WW'(WDOG_CYC - 1);

  typedef enum logic [1:0] {COLLECT, TERMWAIT, RESYNC} state_t;

  state_t                 state, state_nx;
  logic [IW-1:0]          idx, idx_nx;
  logic [TW-1:0]          tmr;
  logic [WW-1:0]          wdog;
  logic [CW-1:0]          cnt;
  logic [N_CH-1:0][7:0]   shadow, pend, duty;
  logic                   pend_vld;
  logic                   store, accept, bad_term, tmr_active, tmo, wrap;
  logic [PW-1:0]          thr [N_CH];
  logic [N_CH-1:0]        pwm_nx;

  assign duty_bus = duty;
  assign wrap     = (cnt == CNT_LAST);

  always_comb begin
    state_nx   = state;
    idx_nx     = idx;
    store      = 1'b0;
    accept     = 1'b0;
    bad_term   = 1'b0;
    tmr_active = ((state == COLLECT) && (idx != '0)) || (state == TERMWAIT);
    // a byte arriving in the last timer cycle still counts as on time
    tmo        = tmr_active && !rx_valid && (tmr == TMR_LAST);
    case (state)
      COLLECT: begin
        if (rx_valid) begin
          store = 1'b1;
          if (idx == IDX_LAST) begin
            state_nx = TERMWAIT;
            idx_nx   = '0;
          end else begin
            idx_nx = idx + IW'(1);
          end
        end else if (tmo) begin
          idx_nx = '0;
        end
      end
      TERMWAIT: begin
        if (rx_valid) begin
          idx_nx = '0;
          if (rx_data == TERM) begin
            accept   = 1'b1;
            state_nx = COLLECT;
          end else begin
            bad_term = 1'b1;
            state_nx = RESYNC;
          end
        end else if (tmo) begin
          state_nx = COLLECT;
        end
      end
      RESYNC: begin
        if (rx_valid && (rx_data == TERM)) state_nx = COLLECT;
      end
      default: state_nx = COLLECT;
    endcase
  end

  always_comb begin
    pwm_nx = '0;
    for (int i = 0; i < N_CH; i++) begin
      thr[i] = (PW'(duty[i]) * PW'(PERIOD_CNT)) >> 8;
      if (duty[i] == 8'hFF)      pwm_nx[i] = 1'b1;
      else if (duty[i] == 8'h00) pwm_nx[i] = 1'b0;
      else                       pwm_nx[i] = (PW'(cnt) < thr[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset_uart) begin
      state        <= COLLECT;
      idx          <= '0;
      shadow       <= '0;
      pend         <= '0;
      pend_vld     <= 1'b0;
      duty         <= '0;
      tmr          <= '0;
      wdog         <= '0;
      cnt          <= '0;
      pwm_out      <= '0;
      frame_strobe <= 1'b0;
      frame_err    <= 1'b0;
      err_count    <= '0;
      link_ok      <= 1'b0;
    end else begin
      state        <= state_nx;
      idx          <= idx_nx;
      if (store) shadow[idx] <= rx_data;
      tmr          <= (tmr_active && !rx_valid && !tmo) ? tmr + TW'(1) : '0;
      frame_strobe <= accept;
      frame_err    <= bad_term || tmo;
      if ((bad_term || tmo) && (err_count != 16'hFFFF)) err_count <= err_count + 16'd1;

      cnt <= wrap ? '0 : cnt + CW'(1);
      if (wrap && pend_vld) begin
        duty     <= pend;
        pend_vld <= 1'b0;
      end

      // acceptance beats expiry; expiry overrides a same-cycle apply
      if (accept) begin
        pend     <= shadow;
        pend_vld <= 1'b1;
        link_ok  <= 1'b1;
        wdog     <= '0;
      end else if (wdog == WD_LAST) begin
        link_ok  <= 1'b0;
        duty     <= '0;
        pend_vld <= 1'b0;
      end else begin
        wdog <= wdog + WW'(1);
      end

      pwm_out <= pwm_nx;
    end
  end

endmodule

// File: tb/tb_uart_pwm_frame_ctrl.sv
// Self-checking bench: vector table, hand-written corner sequences, and random bytes against a reference model.
module tb_uart_pwm_frame_ctrl;

  localparam int         N    = 2;
  localparam int         P    = 100;
  localparam logic [7:0] TERM = 8'h0A;
  localparam int         BT   = 50;
  localparam int         WD   = 1000;

  logic            clk = 1'b0;
  logic            reset_uart;
  logic            rx_valid;
  logic [7:0]      rx_data;
  logic [N-1:0]    pwm_out;
  logic [8*N-1:0]  duty_bus;
  logic            frame_strobe, frame_err, link_ok;
  logic [15:0]     err_count;

  uart_pwm_frame_ctrl #(.N_CH(N), .PERIOD_CNT(P), .TERM(TERM), .BYTE_TMO(BT), .WDOG_CYC(WD)) dut (
    .clk(clk), .reset_uart(reset_uart), .rx_valid(rx_valid), .rx_data(rx_data),
    .pwm_out(pwm_out), .duty_bus(duty_bus), .frame_strobe(frame_strobe),
    .frame_err(frame_err), .err_count(err_count), .link_ok(link_ok)
  );

  always #5 clk = ~clk;

  // Reference model: frame bytes held in a queue, timers as plain integers.
  int         m_cnt = 0, m_gap = 0, m_wd = 0, m_errcnt = 0;
  bit         m_pv = 0, m_resync = 0, m_link = 0, m_strobe = 0, m_err = 0;
  logic [7:0] m_pend [N];
  logic [7:0] m_act  [N];
  logic [7:0] m_q [$];
  logic [N-1:0] m_pwm = '0;

  task automatic model_step(input logic v, input logic [7:0] d, input logic rst);
    int         o_cnt;
    bit         o_pv, acc, e;
    logic [7:0] o_act [N];
    logic [7:0] o_pend [N];
    logic [7:0] newf [N];
    if (rst) begin
      m_cnt = 0; m_gap = 0; m_wd = 0; m_errcnt = 0;
      m_pv = 0; m_resync = 0; m_link = 0; m_strobe = 0; m_err = 0;
      m_q.delete(); m_pwm = '0;
      for (int i = 0; i < N; i++) begin m_act[i] = 8'h00; m_pend[i] = 8'h00; end
      return;
    end
    o_cnt = m_cnt; o_pv = m_pv; o_act = m_act; o_pend = m_pend;
    acc = 0; e = 0;
    for (int i = 0; i < N; i++) newf[i] = 8'h00;
    if (m_resync) begin
      if (v && d == TERM) m_resync = 0;
    end else if (v) begin
      m_gap = 0;
      if (m_q.size() < N) m_q.push_back(d);
      else begin
        if (d == TERM) begin
          acc = 1;
          for (int i = 0; i < N; i++) newf[i] = m_q[i];
        end else begin
          e = 1; m_resync = 1;
        end
        m_q.delete();
      end
    end else if (m_q.size() > 0) begin
      if (m_gap == BT - 1) begin e = 1; m_q.delete(); m_gap = 0; end
      else m_gap++;
    end
    for (int i = 0; i < N; i++) begin
      if (o_act[i] == 8'hFF)      m_pwm[i] = 1'b1;
      else if (o_act[i] == 8'h00) m_pwm[i] = 1'b0;
      else                        m_pwm[i] = (o_cnt < (int'(o_act[i]) * P) / 256);
    end
    m_cnt = (o_cnt == P - 1) ? 0 : o_cnt + 1;
    if (o_cnt == P - 1 && o_pv) begin m_act = o_pend; m_pv = 0; end
    if (acc) begin
      m_pend = newf; m_pv = 1; m_link = 1; m_wd = 0;
    end else if (m_wd == WD - 1) begin
      m_link = 0; m_pv = 0;
      for (int i = 0; i < N; i++) m_act[i] = 8'h00;
    end else m_wd++;
    m_strobe = acc; m_err = e;
    if (e && m_errcnt < 65535) m_errcnt++;
  endtask

  always @(posedge clk) model_step(rx_valid, rx_data, reset_uart);

  int n_chk = 0, n_pass = 0, n_fail = 0;
  int strobe_seen = 0, err_seen = 0, hi0 = 0, hi1 = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else begin
      if (n_fail < 40) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      n_fail++;
    end
  endtask

  task automatic tick();
    logic [8*N-1:0] ed;
    @(negedge clk);
    for (int i = 0; i < N; i++) ed[8*i +: 8] = m_act[i];
    chk("mdl_pwm",    32'(pwm_out),      32'(m_pwm));
    chk("mdl_duty",   32'(duty_bus),     32'(ed));
    chk("mdl_strobe", 32'(frame_strobe), 32'(m_strobe));
    chk("mdl_err",    32'(frame_err),    32'(m_err));
    chk("mdl_errcnt", 32'(err_count),    32'(m_errcnt));
    chk("mdl_link",   32'(link_ok),      32'(m_link));
    strobe_seen += int'(frame_strobe);
    err_seen    += int'(frame_err);
    hi0         += int'(pwm_out[0]);
    hi1         += int'(pwm_out[1]);
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1; rx_data = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] b);
    send_byte(a); idle(1); send_byte(b); idle(1); send_byte(TERM);
  endtask

  task automatic wait_strobe(input string name);
    int n = 0;
    while (!frame_strobe && n < 20) begin tick(); n++; end
    chk(name, 32'(frame_strobe), 32'd1);
  endtask

  typedef struct {
    logic [7:0]  b0, b1, b2;
    int          nb, exp_str, exp_err;
    logic [15:0] exp_duty;
    int          exp_h0, exp_h1, exp_ec;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int s0, e0, a0, a1, exp_ec;
    logic [7:0] bb;
    vecs[0] = '{8'h80, 8'h40, 8'h0A, 3, 1, 0, 16'h4080, 50, 25, 0};
    vecs[1] = '{8'h80, 8'h40, 8'h55, 3, 0, 1, 16'h4080, 50, 25, 1};
    vecs[2] = '{8'h11, 8'h0A, 8'h00, 2, 0, 0, 16'h4080, 50, 25, 1};
    vecs[3] = '{8'h20, 8'h10, 8'h0A, 3, 1, 0, 16'h1020, 12,  6, 1};
    vecs[4] = '{8'hFF, 8'h00, 8'h0A, 3, 1, 0, 16'h00FF, 100, 0, 1};
    vecs[5] = '{8'h01, 8'hFE, 8'h0A, 3, 1, 0, 16'hFE01, 0,  99, 1};

    reset_uart = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    idle(3);
    chk("rst_pwm",    32'(pwm_out),      32'd0);
    chk("rst_duty",   32'(duty_bus),     32'd0);
    chk("rst_strobe", 32'(frame_strobe), 32'd0);
    chk("rst_err",    32'(frame_err),    32'd0);
    chk("rst_errcnt", 32'(err_count),    32'd0);
    chk("rst_link",   32'(link_ok),      32'd0);
    reset_uart = 1'b0;
    idle(2);

    for (int v = 0; v < 6; v++) begin
      s0 = strobe_seen; e0 = err_seen;
      for (int k = 0; k < vecs[v].nb; k++) begin
        bb = (k == 0) ? vecs[v].b0 : (k == 1) ? vecs[v].b1 : vecs[v].b2;
        send_byte(bb); idle(1);
      end
      idle(3);
      chk("vec_strobe", 32'(strobe_seen - s0), 32'(vecs[v].exp_str));
      chk("vec_err",    32'(err_seen - e0),    32'(vecs[v].exp_err));
      idle(102);
      chk("vec_duty",   32'(duty_bus),  32'(vecs[v].exp_duty));
      chk("vec_errcnt", 32'(err_count), 32'(vecs[v].exp_ec));
      chk("vec_link",   32'(link_ok),   32'd1);
      a0 = hi0; a1 = hi1;
      idle(100);
      chk("vec_hi0", 32'(hi0 - a0), 32'(vecs[v].exp_h0));
      chk("vec_hi1", 32'(hi1 - a1), 32'(vecs[v].exp_h1));
    end
    exp_ec = 1;

    // inter-byte timeout discards a lone byte
    e0 = err_seen;
    send_byte(8'h80);
    idle(49);
    chk("tmo_early", 32'(err_seen - e0), 32'd0);
    idle(1);
    chk("tmo_pulse", 32'(err_seen - e0), 32'd1);
    exp_ec++;
    chk("tmo_errcnt", 32'(err_count), 32'(exp_ec));
    idle(10);
    s0 = strobe_seen;
    send_frame(8'h30, 8'h20);
    idle(105);
    chk("tmo_strobe", 32'(strobe_seen - s0), 32'd1);
    chk("tmo_duty",   32'(duty_bus), 32'h2030);

    // watchdog expiry exactly WD cycles after the accepting edge
    send_frame(8'h55, 8'h66);
    wait_strobe("wd_strobe");
    idle(WD - 1);
    chk("wd_link_before", 32'(link_ok), 32'd1);
    idle(1);
    chk("wd_link_after", 32'(link_ok),  32'd0);
    chk("wd_duty_clr",   32'(duty_bus), 32'd0);
    idle(1);
    chk("wd_pwm_off",    32'(pwm_out),  32'd0);
    idle(20);
    send_frame(8'h77, 8'h22);
    wait_strobe("wd_restore_strobe");
    chk("wd_restore_link", 32'(link_ok),  32'd1);
    chk("wd_restore_hold", 32'(duty_bus), 32'd0);
    idle(105);
    chk("wd_restore_duty", 32'(duty_bus), 32'h2277);

    // reset in the middle of a frame
    send_byte(8'h11);
    reset_uart = 1'b1;
    tick();
    reset_uart = 1'b0;
    chk("mid_rst_pwm",    32'(pwm_out),   32'd0);
    chk("mid_rst_duty",   32'(duty_bus),  32'd0);
    chk("mid_rst_errcnt", 32'(err_count), 32'd0);
    chk("mid_rst_link",   32'(link_ok),   32'd0);
    idle(2);
    send_frame(8'h44, 8'h33);
    wait_strobe("mid_rst_strobe");
    idle(105);
    chk("mid_rst_duty2", 32'(duty_bus), 32'h3344);

    // random byte traffic against the model
    for (int c = 0; c < 6000; c++) begin
      if (c % 1500 == 300) begin rx_valid = 1'b0; reset_uart = 1'b0; idle(55); end
      if (c % 1500 == 700) begin rx_valid = 1'b0; reset_uart = 1'b0; idle(1100); end
      rx_valid   = ($urandom_range(0, 2) == 0);
      rx_data    = ($urandom_range(0, 1) == 0) ? TERM : 8'($urandom_range(0, 255));
      reset_uart = ($urandom_range(0, 2999) == 0);
      tick();
    end
    rx_valid = 1'b0; reset_uart = 1'b0;
    idle(5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_pwm_frame_ctrl.md
Name: uart_pwm_frame_ctrl

Overview:
Parametrised multi-channel successor to the single-purpose UART-to-PWM path. It consumes the byte stream from uart_rx (valid/data strobe) and parses fixed-length frames of N_CH duty bytes followed by a terminator byte. It validates each frame, handles resynchronisation and inter-byte timeouts, and applies duties atomically at PWM period boundaries. It drives N_CH PWM outputs and a link watchdog that forces all outputs low when the host goes silent.

Parameters:
N_CH, 2, number of PWM channels / duty bytes per frame (1..16)
PERIOD_CNT, 27027, PWM period in clk cycles (≥2)
TERM, 8'h0A, frame terminator byte
BYTE_TMO, 270270, max clk cycles between bytes inside one frame
WDOG_CYC, 27027027, clk cycles without a valid frame before link loss

Ports:
clk  in  1  system clock
reset_uart  in  1  synchronous, active-high reset
rx_valid  in  1  one-cycle strobe, rx_data valid
rx_data  in  8  received byte
pwm_out  out  N_CH  PWM outputs, bit i = channel i
duty_bus  out  8*N_CH  active duty bytes, channel i at [8i+7:8i]
frame_strobe  out  1  one-cycle pulse, valid frame accepted
frame_err  out  1  one-cycle pulse, frame discarded
err_count  out  16  saturating count of discarded frames
link_ok  out  1  high while watchdog not expired

Behaviour:
- Reset (reset_uart=1 at a clk edge): pwm_out=0, duty_bus=0, frame_strobe=0, frame_err=0, err_count=0, link_ok=0. Parser to COLLECT idx 0, period counter=0, pending flag=0, timers=0. This applies mid-frame too; partial bytes are lost.
- Parser states: COLLECT (idx 0..N_CH-1), TERMWAIT, RESYNC.
- COLLECT: on rx_valid, store rx_data to shadow[idx]. Increment idx. After byte N_CH-1, go to TERMWAIT. Data bytes are not checked against TERM; any value is legal.
- TERMWAIT: on rx_valid with rx_data==TERM, copy shadow into pending and set pending. Pulse frame_strobe on the next cycle (registered). Clear the watchdog. Return to COLLECT idx 0.
- TERMWAIT: on rx_valid with rx_data!=TERM, pulse frame_err next cycle, increment err_count (saturate at 16'hFFFF), go to RESYNC.
- RESYNC: discard bytes until a TERM byte, then go to COLLECT idx 0. No strobe or error pulse on leaving RESYNC.
- Inter-byte timer: runs while in COLLECT with idx>0, or in TERMWAIT. It clears on each rx_valid. When it reaches BYTE_TMO-1, the partial frame is discarded, frame_err pulses, err_count increments, and the parser goes to COLLECT idx 0. The timer is idle in COLLECT idx 0 and in RESYNC.
- Period counter: 0..PERIOD_CNT-1, wraps to 0. It is shared by all channels.
- Duty apply: in the cycle the counter wraps to 0 with pending=1, the active duties take the pending values and pending clears. If a second frame lands before the boundary, it overwrites pending (latest wins). If pending is set and the boundary occur in the same cycle, the new value is applied at the following boundary.
- Compare value: thr_i = (duty_i * PERIOD_CNT) >> 8, computed in 8+clog2(PERIOD_CNT+1) bits.
- pwm_out[i] (registered) is 1 when cnt < thr_i, with two overrides:
  - duty_i==8'hFF: constant 1.
  - duty_i==8'h00: constant 0.
- Watchdog: counts every cycle and clears on frame acceptance.
  - When it reaches WDOG_CYC-1: link_ok drops, active duties and pending are cleared immediately, and pwm_out=0 from the next cycle.
  - It then saturates.
  - The next valid frame sets link_ok=1 (same cycle as frame_strobe). Its duties apply at the next boundary.
- link_ok stays 0 after reset until the first valid frame.
- Simultaneous frame acceptance and watchdog expiry: acceptance wins.

Test Plan:
1. N_CH=2, PERIOD_CNT=100, TERM=8'h0A; send 80,40,0A → one frame_strobe pulse, link_ok=1. After the next wrap, pwm_out[0] high 50 of 100 cycles and pwm_out[1] high 25; duty_bus=16'h4080.
2. Send 80,40,55 then 11,0A then 20,10,0A → frame_err once, err_count=1, duties unchanged until the third group. Then duty_bus=16'h1020 (thr 12 and 6).
3. Frames FF,00,0A then 01,FE,0A → first: ch0 constant high, ch1 constant low. Second: ch0 thr=0, so always low; ch1 thr=99, so high 99 cycles.
4. BYTE_TMO=50; send 80, idle 60 cycles, then 30,20,0A → frame_err at the timeout, err_count=1. The accepted frame is duty_bus=16'h2030, not containing 80.
5. WDOG_CYC=1000; one valid frame, then silence → link_ok falls exactly 1000 cycles after the accepting edge and pwm_out=0. A new frame restores link_ok, and duties apply at the next wrap.
6. Assert reset_uart for 1 cycle after byte 1 of a frame → all outputs 0 and err_count=0. The subsequent full frame is accepted normally with frame_strobe=1.
